// File: rtl/rv64_pkg.sv
// Shared RV64 execute-stage definitions: M-extension op encodings, muldiv FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package rv64_pkg;

    localparam int XLEN = 64;

    // funct3 encodings of the M extension; the *W forms set bit MD_WORD of the op.
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;
    localparam int         MD_WORD   = 3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide: radix-2 shift-add and restoring divide on one accumulator.
// Latency: N+1 cycles issue-to-result (N=64, or 32 for *W); divide-by-zero/overflow in 1 cycle.
// Backpressure: o_busy stalls the front end until the one-cycle o_valid strobe; i_flush aborts.
module ex_muldiv
    import rv64_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_srca,
    input  logic [DATA_WIDTH-1:0] i_srcb,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result
);

    md_state_e         state;
    logic [5:0]        cnt;
    logic [127:0]      acc;
    logic [XLEN-1:0]   b_mag;
    logic              op_div;
    logic              op_rem;
    logic              op_word;
    logic              op_hi;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   result_q;

    // Issue-time operand preparation, evaluated straight off the ID/EX operands.
    logic [2:0]        iss_f3;
    logic              iss_word;
    logic              iss_div;
    logic              iss_a_signed;
    logic              iss_b_signed;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag_iss;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   spec_raw;
    logic [XLEN-1:0]   spec_res;
    logic [127:0]      acc_init;

    always_comb begin
        iss_f3       = i_op[2:0];
        iss_word     = i_op[MD_WORD];
        iss_div      = iss_f3[2];
        iss_a_signed = iss_div ? ~iss_f3[0]
                               : (~iss_word & ((iss_f3 == MD_MULH) | (iss_f3 == MD_MULHSU)));
        iss_b_signed = iss_div ? ~iss_f3[0] : (~iss_word & (iss_f3 == MD_MULH));

        if (iss_word) begin
            a_ext = iss_a_signed ? sext32(i_srca[31:0]) : {32'b0, i_srca[31:0]};
            b_ext = iss_b_signed ? sext32(i_srcb[31:0]) : {32'b0, i_srcb[31:0]};
        end else begin
            a_ext = i_srca;
            b_ext = i_srcb;
        end

        a_neg     = iss_a_signed & a_ext[XLEN-1];
        b_neg     = iss_b_signed & b_ext[XLEN-1];
        a_mag     = a_neg ? (64'd0 - a_ext) : a_ext;
        b_mag_iss = b_neg ? (64'd0 - b_ext) : b_ext;

        div_zero = iss_div & (b_ext == 64'd0);
        div_ovf  = iss_div & iss_a_signed & (&b_ext)
                 & (a_ext == (iss_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

        if (iss_f3[1])
            spec_raw = div_zero ? a_ext : 64'd0;
        else
            spec_raw = div_zero ? 64'hFFFF_FFFF_FFFF_FFFF : a_ext;
        spec_res = iss_word ? sext32(spec_raw[31:0]) : spec_raw;

        // A 32-step divide must see the dividend's MSB first, so park it in the upper half.
        if (iss_div & iss_word)
            acc_init = {64'd0, a_mag[31:0], 32'd0};
        else
            acc_init = {64'd0, a_mag};
    end

    // One shared adder: multiplier adds b into the high half, divider subtracts b from it.
    logic [65:0]       alu_x;
    logic [65:0]       alu_y;
    logic [65:0]       alu_sum;
    logic [127:0]      acc_nxt;

    always_comb begin
        alu_x   = op_div ? {1'b0, acc[127:63]} : {2'b0, acc[127:64]};
        alu_y   = op_div ? ~{2'b0, b_mag} : {2'b0, (acc[0] ? b_mag : 64'd0)};
        alu_sum = alu_x + alu_y + {65'd0, op_div};
        if (op_div)
            acc_nxt = alu_sum[65] ? {acc[126:0], 1'b0} : {alu_sum[63:0], acc[62:0], 1'b1};
        else
            acc_nxt = {alu_sum[64:0], acc[63:1]};
    end

    logic [127:0]      prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        prod = neg_q ? (128'd0 - acc_nxt) : acc_nxt;
        // Word multiply leaves its 64-bit product in acc[95:32]; only the low word is kept.
        if (op_word)
            mul_res = sext32(acc_nxt[63:32]);
        else
            mul_res = op_hi ? prod[127:64] : prod[63:0];

        quo     = neg_q ? (64'd0 - acc_nxt[63:0])   : acc_nxt[63:0];
        rem     = neg_r ? (64'd0 - acc_nxt[127:64]) : acc_nxt[127:64];
        div_sel = op_rem ? rem : quo;
        div_res = op_word ? sext32(div_sel[31:0]) : div_sel;

        fin_res = op_div ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            cnt      <= 6'd0;
            acc      <= 128'd0;
            b_mag    <= 64'd0;
            op_div   <= 1'b0;
            op_rem   <= 1'b0;
            op_word  <= 1'b0;
            op_hi    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= 64'd0;
        end else if (i_flush) begin
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (i_start) begin
                        acc     <= acc_init;
                        b_mag   <= b_mag_iss;
                        op_div  <= iss_div;
                        op_rem  <= iss_f3[1];
                        op_word <= iss_word;
                        op_hi   <= ~iss_word & (iss_f3 != MD_MUL);
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        if (div_zero | div_ovf) begin
                            result_q <= spec_res;
                            state    <= MD_DONE;
                        end else begin
                            cnt   <= iss_word ? 6'd31 : 6'd63;
                            state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    acc <= acc_nxt;
                    if (cnt == 6'd0) begin
                        result_q <= fin_res;
                        state    <= MD_DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign o_busy   = (state == MD_CALC) | ((state == MD_IDLE) & i_start & ~i_flush);
    assign o_valid  = (state == MD_DONE) & ~i_flush;
    assign o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [3:0]  i_op;
    logic [63:0] i_srca;
    logic [63:0] i_srcb;
    logic        i_flush;
    logic        o_busy;
    logic        o_valid;
    logic [63:0] o_result;

    int total = 0;
    int bad   = 0;

    ex_muldiv #(.DATA_WIDTH(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_srca   (i_srca),
        .i_srcb   (i_srcb),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: result and issue-to-valid cycle count from plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output int lat);
        logic         w;
        logic [2:0]   f3;
        logic [127:0] p;
        logic [63:0]  x, y, q, r, o;
        logic         sgn;
        w  = op[3];
        f3 = op[2:0];
        res = 64'd0;
        if (!f3[2]) begin
            lat = w ? 33 : 65;
            if (w) begin
                p   = {64'd0, a} * {64'd0, b};
                res = sx32(p[31:0]);
            end else begin
                case (f3)
                    3'b000: p = {64'd0, a} * {64'd0, b};
                    3'b001: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
                    3'b010: p = {{64{a[63]}}, a} * {64'd0, b};
                    default: p = {64'd0, a} * {64'd0, b};
                endcase
                res = (f3 == 3'b000) ? p[63:0] : p[127:64];
            end
        end else begin
            sgn = ~f3[0];
            if (w) begin
                x = sgn ? sx32(a[31:0]) : {32'd0, a[31:0]};
                y = sgn ? sx32(b[31:0]) : {32'd0, b[31:0]};
            end else begin
                x = a;
                y = b;
            end
            if (y == 64'd0) begin
                q = '1; r = x; lat = 1;
            end else if (sgn && y == '1 &&
                         x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
                q = x; r = 64'd0; lat = 1;
            end else begin
                lat = w ? 33 : 65;
                if (sgn) begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                end else begin
                    q = x / y;
                    r = x % y;
                end
            end
            o   = f3[1] ? r : q;
            res = w ? sx32(o[31:0]) : o;
        end
    endfunction

    // Issue at the current negedge (cycle 0); returns at the negedge of cycle lat+1.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input string tag);
        logic [63:0] exp_res;
        logic [63:0] got;
        int          exp_lat;
        int          lat;
        bit          busy_ok;
        model(op, a, b, exp_res, exp_lat);
        i_start = 1'b1; i_op = op; i_srca = a; i_srcb = b;
        #1;
        check_eq({tag, "_busy0"}, {63'd0, o_busy}, 64'd1);
        check_eq({tag, "_valid0"}, {63'd0, o_valid}, 64'd0);
        lat = -1;
        busy_ok = 1'b1;
        got = 64'd0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            // Noise on the issue inputs must not disturb an operation in flight.
            i_start = 1'($urandom_range(0, 1));
            i_op    = 4'($urandom);
            i_srca  = {$urandom, $urandom};
            i_srcb  = {$urandom, $urandom};
            #1;
            if (o_valid) begin
                lat = c;
                got = o_result;
                if (o_busy) busy_ok = 1'b0;
                i_start = 1'b0;
                break;
            end
            if (!o_busy) busy_ok = 1'b0;
        end
        i_start = 1'b0;
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, got, exp_res);
        check_eq({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        @(negedge clk);
        #1;
        check_eq({tag, "_valid_once"}, {63'd0, o_valid}, 64'd0);
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(32'h8000_0000);
            4: return 64'($urandom_range(0, 20));
            5: return sx32($urandom);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit quiet;
        rst_n = 1'b0; i_start = 1'b0; i_op = 4'd0; i_srca = 64'd0; i_srcb = 64'd0; i_flush = 1'b0;
        #1;
        check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("rst_result", o_result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b0000, 64'd7, -64'sd3, "mul_7x-3");
        run_op(4'b0011, '1, '1, "mulhu_max");
        run_op(4'b0001, '1, '1, "mulh_m1");
        run_op(4'b0100, -64'sd7, 64'd2, "div_-7_2");
        run_op(4'b0110, -64'sd7, 64'd2, "rem_-7_2");
        run_op(4'b1101, 64'h1_0000_0009, 64'd4, "divuw");
        run_op(4'b0101, 64'd5, 64'd0, "divu_0");
        run_op(4'b0111, 64'd5, 64'd0, "remu_0");
        run_op(4'b0100, 64'h8000_0000_0000_0000, '1, "div_ovf");
        run_op(4'b1100, 64'h8000_0000, '1, "divw_ovf");
        run_op(4'b0010, -64'sd5, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu");
        run_op(4'b1000, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0003, "mulw");

        // Flush a DIV in cycle 10, then issue MUL 3x4 in cycle 11.
        i_start = 1'b1; i_op = 4'b0100; i_srca = 64'd100; i_srcb = 64'd7;
        quiet = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_flush = (c == 10);
            #1;
            if (o_valid && c < 10) quiet = 1'b0;
        end
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check_eq("flush_busy", {63'd0, o_busy}, 64'd0);
        check_eq("flush_valid", {63'd0, o_valid | ~quiet}, 64'd0);
        run_op(4'b0000, 64'd3, 64'd4, "mul_after_flush");

        // Reset in cycle 20 of a MUL.
        i_start = 1'b1; i_op = 4'b0000; i_srca = 64'd9; i_srcb = 64'd9;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("midrst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("midrst_result", o_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start together with flush must be dropped.
        i_start = 1'b1; i_flush = 1'b1; i_op = 4'b0000; i_srca = 64'd5; i_srcb = 64'd6;
        #1;
        check_eq("stfl_busy", {63'd0, o_busy}, 64'd0);
        quiet = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            i_start = 1'b0; i_flush = 1'b0;
            #1;
            if (o_valid || o_busy) quiet = 1'b0;
        end
        check_eq("stfl_quiet", {63'd0, quiet}, 64'd1);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            run_op(op, rnd_val(), rnd_val(), $sformatf("rnd%0d_op%0h", n, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
